// File: rtl/srl_sra_seq.sv
// -----------------------------------------------------------------------------
// srl_sra_seq
//
// Multicycle logical/arithmetic right shifter for the execute stage. The
// operand is loaded into a working register and shifted right by up to
// SHIFT_PER_CYCLE bit positions per cycle until the requested shift amount
// has been consumed. A start/valid handshake lets the ALU control stall the
// pipeline while a shift is in progress.
//
// Parameters:
//   SHIFT_PER_CYCLE  bit positions shifted per SHIFT cycle (1, 2, 4, 8 or 16)
//
// Ports:
//   i_clk        core clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      request a new shift (taken in IDLE or DONE only)
//   i_flush      pipeline flush, aborts the operation in flight
//   i_arith      1 = SRA (sign fill), 0 = SRL (zero fill), latched at accept
//   i_rotate     (SRL_ROTATE_EN builds only) 1 = rotate right, latched at accept
//   i_operand_a  value to shift
//   i_operand_b  shift amount
//   o_busy       high while shifting
//   o_valid      one-cycle pulse, o_srl_data is final
//   o_srl_data   working/result register
//
// Build option:
//   SRL_ROTATE_EN  when defined, adds i_rotate and a rotate-right mode
//                  (Zbb ROR/RORI) with identical timing and handshake.
// -----------------------------------------------------------------------------
module srl_sra_seq #(
    parameter int SHIFT_PER_CYCLE = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic        i_arith,
`ifdef SRL_ROTATE_EN
    input  logic        i_rotate,
`endif
    input  logic [31:0] i_operand_a,
    input  logic [4:0]  i_operand_b,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_srl_data
);

    // Only power-of-two steps up to 16 keep the per-cycle shifter small.
    generate
        if (SHIFT_PER_CYCLE != 1 && SHIFT_PER_CYCLE != 2 && SHIFT_PER_CYCLE != 4 &&
            SHIFT_PER_CYCLE != 8 && SHIFT_PER_CYCLE != 16) begin : g_bad_step
            $error("srl_sra_seq: SHIFT_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] STEP = 5'(SHIFT_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  rem_q, rem_d;
    logic        fill_q, fill_d;
`ifdef SRL_ROTATE_EN
    logic        rotate_q, rotate_d;
`endif

    logic [4:0]  stepK;
    logic [4:0]  remNext;
    logic [63:0] extended;
    logic [63:0] extShifted;
    logic [31:0] shifted;

    // Per-cycle datapath. The working word is extended to 64 bits with the
    // fill bit (or with a second copy of itself when rotating) so a single
    // logical right shift yields the filled/rotated result in the low half.
    always_comb begin
        stepK    = (rem_q < STEP) ? rem_q : STEP;
        remNext  = rem_q - stepK;
        extended = {{32{fill_q}}, data_q};
`ifdef SRL_ROTATE_EN
        if (rotate_q) begin
            extended = {data_q, data_q};
        end
`endif
        extShifted = extended >> stepK;
        shifted    = extShifted[31:0];
    end

    // Next-state logic. Flush wins over start; start is only honoured in
    // IDLE or DONE so DONE can hand over to a new operation without a bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
`ifdef SRL_ROTATE_EN
        rotate_d = rotate_q;
`endif
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        data_d  = i_operand_a;
                        fill_d  = i_arith & i_operand_a[31];
                        rem_d   = i_operand_b;
`ifdef SRL_ROTATE_EN
                        rotate_d = i_rotate;
`endif
                        state_d = (i_operand_b != 5'd0) ? SHIFT : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    data_d = shifted;
                    rem_d  = remNext;
                    if (remNext == 5'd0) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= 32'h0;
            rem_q   <= 5'd0;
            fill_q  <= 1'b0;
`ifdef SRL_ROTATE_EN
            rotate_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
`ifdef SRL_ROTATE_EN
            rotate_q <= rotate_d;
`endif
        end
    end

    assign o_busy     = (state_q == SHIFT);
    assign o_valid    = (state_q == DONE);
    assign o_srl_data = data_q;

endmodule

// File: tb/tb_srl_sra_seq.sv
// -----------------------------------------------------------------------------
// tb_srl_sra_seq
//
// Self-checking bench for srl_sra_seq. Two instances are exercised: one with
// the default step of 4 bits per cycle and one stepping a single bit per
// cycle. Issued operations push their expected result and expected valid
// cycle into a per-instance queue; a monitor per instance pops and compares
// whenever o_valid is seen. Define SRL_ROTATE_EN to also cover rotate mode.
// -----------------------------------------------------------------------------
module tb_srl_sra_seq;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start0, start1;
    logic        flush0;
    logic        flush1;
    logic        arith;
    logic [31:0] opA;
    logic [4:0]  opB;
`ifdef SRL_ROTATE_EN
    logic        rotate;
`endif
    logic        busy0, valid0, busy1, valid1;
    logic [31:0] data0, data1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    assign flush1 = 1'b0;

    // Free-running clock and cycle counter used for latency expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    srl_sra_seq #(.SHIFT_PER_CYCLE(4)) u_dut0 (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (start0),
        .i_flush     (flush0),
        .i_arith     (arith),
`ifdef SRL_ROTATE_EN
        .i_rotate    (rotate),
`endif
        .i_operand_a (opA),
        .i_operand_b (opB),
        .o_busy      (busy0),
        .o_valid     (valid0),
        .o_srl_data  (data0)
    );

    srl_sra_seq #(.SHIFT_PER_CYCLE(1)) u_dut1 (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (start1),
        .i_flush     (flush1),
        .i_arith     (arith),
`ifdef SRL_ROTATE_EN
        .i_rotate    (rotate),
`endif
        .i_operand_a (opA),
        .i_operand_b (opB),
        .o_busy      (busy1),
        .o_valid     (valid1),
        .o_srl_data  (data1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives a one-cycle start pulse (caller sits at a negedge) and records
    // the expected result. Operands are scrambled right after acceptance.
    task automatic applyStimulus(input int which, input string name,
                                 input logic [31:0] a, input logic [4:0] b,
                                 input logic ar, input logic rot,
                                 input logic [31:0] expData, input bit track);
        exp_t e;
        int   spc;
        spc = (which == 0) ? 4 : 1;
        opA   = a;
        opB   = b;
        arith = ar;
`ifdef SRL_ROTATE_EN
        rotate = rot;
`else
        if (rot) begin
            failures++;
            $display("[TB] FAIL %s: rotate requested, got build without rotate, expected SRL_ROTATE_EN", name);
        end
`endif
        if (which == 0) start0 = 1'b1;
        else            start1 = 1'b1;
        if (track) begin
            e.name = name;
            e.data = expData;
            e.cyc  = cyc + 1 + (int'(b) + spc - 1) / spc;
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        opA    = ~a;
        opB    = ~b;
        arith  = ~ar;
`ifdef SRL_ROTATE_EN
        rotate = ~rot;
`endif
    endtask

    // Counts negedges with o_busy high, bounded so a stuck DUT cannot hang.
    task automatic countBusy(input int which, output int n);
        n = 0;
        while (((which == 0) ? busy0 : busy1) === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Scoreboard monitors: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut0_unexpected_valid: got valid with data %h, expected no pulse", data0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                checkOutput({e.name, "_data"}, data0, e.data);
                checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut1_unexpected_valid: got valid with data %h, expected no pulse", data1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                checkOutput({e.name, "_data"}, data1, e.data);
                checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Watchdog in case something stalls outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        // Reset held with start asserted: nothing may be accepted.
        rstN   = 1'b0;
        start0 = 1'b1;
        start1 = 1'b1;
        flush0 = 1'b0;
        arith  = 1'b1;
        opA    = 32'hFFFF_FFFF;
        opB    = 5'd3;
`ifdef SRL_ROTATE_EN
        rotate = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy0}, 32'd0);
        checkOutput("reset_valid", {31'b0, valid0}, 32'd0);
        checkOutput("reset_data", data0, 32'h0);
        checkOutput("reset_data_spc1", data1, 32'h0);
        rstN   = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_busy", {31'b0, busy0}, 32'd0);
        checkOutput("post_reset_valid", {31'b0, valid0}, 32'd0);

        // Worst-case SRL: eight busy cycles.
        applyStimulus(0, "srl31", 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001, 1'b1);
        countBusy(0, n);
        checkOutput("srl31_busy_cycles", 32'(n), 32'd8);
        repeat (2) @(negedge clk);

        applyStimulus(0, "sra4", 32'hF000_0000, 5'd4, 1'b1, 1'b0, 32'hFF00_0000, 1'b1);
        countBusy(0, n);
        checkOutput("sra4_busy_cycles", 32'(n), 32'd1);
        repeat (2) @(negedge clk);

        applyStimulus(0, "srl4", 32'hF000_0000, 5'd4, 1'b0, 1'b0, 32'h0F00_0000, 1'b1);
        countBusy(0, n);
        repeat (2) @(negedge clk);

        applyStimulus(0, "sra31_neg", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        countBusy(0, n);
        repeat (2) @(negedge clk);

        applyStimulus(0, "sra31_pos", 32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
        countBusy(0, n);
        repeat (2) @(negedge clk);

        applyStimulus(0, "srl13", 32'hA5A5_A5A5, 5'd13, 1'b0, 1'b0, 32'h0005_2D2D, 1'b1);
        countBusy(0, n);
        checkOutput("srl13_busy_cycles", 32'(n), 32'd4);
        repeat (2) @(negedge clk);

        applyStimulus(0, "sra13", 32'hA5A5_A5A5, 5'd13, 1'b1, 1'b0, 32'hFFFD_2D2D, 1'b1);
        countBusy(0, n);
        repeat (2) @(negedge clk);

        // Zero shift, then a back-to-back issue in the DONE cycle.
        applyStimulus(0, "zero", 32'h1234_5678, 5'd0, 1'b0, 1'b0, 32'h1234_5678, 1'b1);
        checkOutput("zero_valid_next_cycle", {31'b0, valid0}, 32'd1);
        applyStimulus(0, "b2b", 32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_000F, 1'b1);
        checkOutput("b2b_busy", {31'b0, busy0}, 32'd1);
        countBusy(0, n);
        repeat (2) @(negedge clk);

        // Flush on the second SHIFT cycle with a competing start.
        applyStimulus(0, "flush", 32'hFFFF_0000, 5'd20, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        flush0 = 1'b1;
        start0 = 1'b1;
        opA    = 32'h1111_1111;
        opB    = 5'd0;
        arith  = 1'b0;
        @(negedge clk);
        flush0 = 1'b0;
        start0 = 1'b0;
        checkOutput("flush_busy", {31'b0, busy0}, 32'd0);
        checkOutput("flush_valid", {31'b0, valid0}, 32'd0);
        checkOutput("flush_data_kept", data0, 32'h0FFF_F000);
        repeat (4) @(negedge clk);
        checkOutput("flush_idle_hold", data0, 32'h0FFF_F000);
        checkOutput("flush_idle_busy", {31'b0, busy0}, 32'd0);

        // Start during SHIFT must be ignored.
        applyStimulus(0, "ignstart", 32'h0000_0100, 5'd8, 1'b0, 1'b0, 32'h0000_0001, 1'b1);
        start0 = 1'b1;
        opA    = 32'hFFFF_FFFF;
        opB    = 5'd0;
        arith  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        countBusy(0, n);
        repeat (2) @(negedge clk);

`ifdef SRL_ROTATE_EN
        applyStimulus(0, "ror8", 32'h1234_5678, 5'd8, 1'b1, 1'b1, 32'h7812_3456, 1'b1);
        countBusy(0, n);
        repeat (2) @(negedge clk);
`endif

        // Single-bit-per-cycle instance.
        applyStimulus(1, "spc1_srl5", 32'h0000_0040, 5'd5, 1'b0, 1'b0, 32'h0000_0002, 1'b1);
        countBusy(1, n);
        checkOutput("spc1_srl5_busy_cycles", 32'(n), 32'd5);
        repeat (2) @(negedge clk);

        applyStimulus(1, "spc1_sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        countBusy(1, n);
        checkOutput("spc1_sra31_busy_cycles", 32'(n), 32'd31);
        repeat (2) @(negedge clk);

`ifdef SRL_ROTATE_EN
        applyStimulus(1, "spc1_ror1", 32'h0000_0001, 5'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        countBusy(1, n);
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        checkOutput("dut0_all_results_seen", 32'(q0.size()), 32'd0);
        checkOutput("dut1_all_results_seen", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
